// File: rtl/clock_ctrl.sv
// clock_ctrl: drives the rollover pulse stream and per-run reset for the divided-clock block.
// First rollover Peff+1 cycles after start is sampled; configuration is accepted only while idle.
module clock_ctrl #(
  parameter int WIDTH      = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int DEF_PERIOD = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [WIDTH-1:0]     i_cfg_period,
  input  logic [CNT_WIDTH-1:0] i_cfg_count,
  output logic                 o_roll_over,
  output logic                 o_clk_reset,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_period;
  logic [WIDTH-1:0]     r_cyc;
  logic [WIDTH-1:0]     w_pmax;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic                 w_cfg_load;
  logic                 w_roll;
  logic                 w_burst;
  logic                 w_last;

  assign w_cfg_load = (r_state == S_IDLE) && i_cfg_valid;

  // A programmed period of 0 behaves as 1, so the wrap point never underflows.
  assign w_pmax  = (r_period == '0) ? '0 : (r_period - WIDTH'(1));
  assign w_roll  = (r_state == S_RUN) && (r_cyc == w_pmax);
  assign w_burst = (r_count != '0);
  assign w_last  = w_roll && w_burst && (r_remaining == CNT_WIDTH'(1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_cfg_ready = 1'b0;
    o_clk_reset = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_roll_over = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_cfg_ready = 1'b1;
        if (i_start && !i_stop) begin
          w_next = S_SYNC;
        end
      end
      S_SYNC: begin
        o_clk_reset = 1'b1;
        o_busy      = 1'b1;
        w_next      = i_stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        o_busy      = 1'b1;
        o_roll_over = w_roll;
        // Stop outranks burst completion, but the decoded rollover still goes out.
        if (i_stop) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_period    <= WIDTH'(DEF_PERIOD);
      r_count     <= '0;
      r_cyc       <= '0;
      r_remaining <= '0;
    end else begin
      if (w_cfg_load) begin
        r_period <= i_cfg_period;
        r_count  <= i_cfg_count;
      end

      if (r_state == S_RUN) begin
        r_cyc <= w_roll ? '0 : (r_cyc + WIDTH'(1));
      end else begin
        r_cyc <= '0;
      end

      // Same-cycle configuration takes effect for the run being started.
      if ((r_state == S_IDLE) && (w_next == S_SYNC)) begin
        r_remaining <= w_cfg_load ? i_cfg_count : r_count;
      end else if (w_roll && w_burst && (r_remaining != '0)) begin
        r_remaining <= r_remaining - CNT_WIDTH'(1);
      end
    end
  end

  assign o_remaining = r_remaining;

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Sequencer for the team's divided-clock generator. It produces the rollover pulse stream that drives the toggling clock block, and issues a one-cycle reset to that block before each run so the generated clock always starts high. It runs a programmable period either continuously or for a fixed burst, and accepts new configuration through a valid/ready handshake while idle.

Parameters:
WIDTH, 8, width of the period register and the cycle counter.
CNT_WIDTH, 8, width of the burst-count register and the remaining-rollover counter.
DEF_PERIOD, 4, period loaded at reset; must be at least 1.

Ports:
i_clk  input  1  system clock; all state changes on the rising edge.
i_reset  input  1  reset, asynchronous, active-low.
i_start  input  1  start request, sampled each cycle.
i_stop  input  1  abort request, sampled each cycle.
i_cfg_valid  input  1  configuration valid.
o_cfg_ready  output  1  configuration accepted this cycle when high together with i_cfg_valid.
i_cfg_period  input  WIDTH  rollover period P in cycles; 0 is treated as 1.
i_cfg_count  input  CNT_WIDTH  burst length N in rollovers; 0 means continuous.
o_roll_over  output  1  one-cycle rollover pulse to the clock block.
o_clk_reset  output  1  one-cycle active-high reset to the clock block.
o_busy  output  1  high in SYNC and RUN.
o_done  output  1  one-cycle pulse when a burst completes normally.
o_remaining  output  CNT_WIDTH  rollovers still to issue in burst mode; 0 in continuous mode.

Behaviour:
- Reset (i_reset low):
  - State forced to IDLE immediately, independent of the clock.
  - Shadow registers: P = DEF_PERIOD, N = 0. Cycle counter = 0, o_remaining = 0.
  - Outputs: o_roll_over, o_clk_reset, o_busy, o_done = 0; o_cfg_ready = 1.
  - Reset mid-run drops all pulses asynchronously. No done is issued.
- All outputs decode from registered state only. No input-to-output combinational path.
- FSM states: IDLE, SYNC, RUN, DONE.
- IDLE:
  - o_cfg_ready = 1. Configuration loads when i_cfg_valid is high on a rising edge.
  - On i_start (and not i_stop), go to SYNC. If start and valid occur in the same cycle, the new configuration applies to this run.
  - If start and stop occur in the same cycle, stop wins and the block stays in IDLE.
- SYNC (1 cycle):
  - o_clk_reset = 1, cycle counter cleared, o_remaining = N.
  - Go to RUN, or to IDLE if i_stop.
- RUN:
  - Cycle counter counts 0 to Peff-1 and wraps, where Peff = max(P, 1).
  - o_roll_over = 1 whenever the counter equals Peff-1. With Peff = 1 it is high every RUN cycle.
  - Burst mode (N != 0): o_remaining decrements on each rollover. The rollover issued while o_remaining = 1 moves the FSM to DONE.
  - Continuous mode (N = 0): runs until stopped.
- DONE (1 cycle): o_done = 1, then go to IDLE.
- i_stop sampled in RUN moves the FSM to IDLE on the next edge. A rollover already decoded in that cycle is still emitted. Stop beats burst completion: no DONE and no o_done.
- i_start while busy is ignored. i_cfg_valid while o_cfg_ready = 0 is ignored; upstream must hold it.
- Counter arithmetic is unsigned. Compare against Peff-1 computed in WIDTH bits. No overflow is possible.
- First-rollover latency: if start is sampled at edge t, SYNC occupies cycle t+1, RUN begins at t+2, and the first rollover occurs in cycle t+1+Peff.

Test Plan:
- Reset defaults: hold i_reset low, then release -> o_cfg_ready = 1, all other outputs 0; a start with no configuration runs at P = 4.
- Burst: configure P = 4, N = 3, then start at edge 0 -> o_clk_reset in cycle 1; o_roll_over in cycles 5, 9 and 13; o_remaining reads 3 → 2 → 1 → 0; o_done in cycle 14; IDLE with o_cfg_ready = 1 in cycle 15.
- Continuous with minimum period: configure P = 0, N = 0, start, stop after 10 cycles -> o_roll_over high every RUN cycle; no o_done; IDLE one cycle after stop is sampled.
- Abort on final rollover: P = 2, N = 2, assert i_stop in the cycle of the second rollover -> pulse still emitted, o_done never asserted, FSM returns to IDLE.
- Handshake and priority: i_cfg_valid with P = 6 during RUN -> not accepted; valid, start and stop together in IDLE -> configuration P = 6 loaded, FSM stays in IDLE.
- Asynchronous reset mid-run: P = 3, continuous, pull i_reset low between clock edges -> o_busy and o_roll_over drop immediately; P restored to 4.
